// File: rtl/btb_pkg.sv
// +--------------------------------------------------------------------+
// | btb_pkg: shared entry/kind types and PC index/tag slice helpers     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package btb_pkg;

  // Tag field is sized for the widest supported TAG_W; narrower tags are stored zero-extended.
  localparam int TAG_W_MAX = 24;

  typedef enum logic [1:0] {
    KIND_BR   = 2'd0,
    KIND_CALL = 2'd1,
    KIND_RET  = 2'd2
  } btb_kind_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [29:0]          target;
    btb_kind_e            kind;
  } btb_entry_t;

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int set_depth);
    return (pc >> 2) & ((32'd1 << set_depth) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int set_depth,
                                         input int tag_w);
    return (pc >> (set_depth + 2)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_ras.sv
// +--------------------------------------------------------------------+
// | btb_ras: circular return-address stack with saturating count        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module btb_ras #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_addr,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      stack [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] count;

  // ptr names the next free slot; overflow wraps onto the oldest entry.
  assign ptr_inc = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
  assign top_idx = (ptr == '0) ? LAST_IDX : ptr - 1'b1;
  assign top     = stack[top_idx];
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (push && pop) begin
      stack[top_idx] <= push_addr;
    end else if (push) begin
      stack[ptr] <= push_addr;
      ptr        <= ptr_inc;
      if (count != FULL_CNT) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/btb_target_buffer.sv
// +--------------------------------------------------------------------+
// | btb_target_buffer: 2-way BTB, F lookup, M training, D pipe regs     |
// | Optional return stack enabled by `define BTB_RAS_EN. Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module btb_target_buffer
  import btb_pkg::*;
#(
  parameter int SET_DEPTH = 6,
  parameter int TAG_W     = 10,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcM,
  input  logic        branchM,
  input  logic        actual_takeM,
  input  logic [31:0] targetM,
  input  logic        callM,
  input  logic        retM,
  output logic        branchF,
  output logic [31:0] targetF,
  output logic        btb_hitD,
  output logic [31:0] btb_targetD
);

  localparam int NSETS = 1 << SET_DEPTH;

  btb_entry_t tbl [2][NSETS];
  logic       lru [NSETS];

  logic [31:0]          idx_f_full, idx_m_full, tag_f_full, tag_m_full;
  logic [SET_DEPTH-1:0] idx_f, idx_m;
  logic [TAG_W_MAX-1:0] tag_f, tag_m;
  btb_entry_t           f0, f1, m0, m1, ent_f, new_ent;
  logic                 hit_f0, hit_f1, hit_f, way_f;
  logic                 hit_m0, hit_m1, hit_m, way_m;
  logic [31:0]          stored_tgt, tgt_f;
  btb_kind_e            kind_m;
  logic                 unused_common;

  assign idx_f_full = pc_index(pcF, SET_DEPTH);
  assign idx_m_full = pc_index(pcM, SET_DEPTH);
  assign tag_f_full = pc_tag(pcF, SET_DEPTH, TAG_W);
  assign tag_m_full = pc_tag(pcM, SET_DEPTH, TAG_W);
  assign idx_f      = idx_f_full[SET_DEPTH-1:0];
  assign idx_m      = idx_m_full[SET_DEPTH-1:0];
  assign tag_f      = tag_f_full[TAG_W_MAX-1:0];
  assign tag_m      = tag_m_full[TAG_W_MAX-1:0];

  assign f0 = tbl[0][idx_f];
  assign f1 = tbl[1][idx_f];
  assign m0 = tbl[0][idx_m];
  assign m1 = tbl[1][idx_m];

  // Way 0 takes precedence when both ways match.
  assign hit_f0     = f0.valid && (f0.tag == tag_f);
  assign hit_f1     = f1.valid && (f1.tag == tag_f);
  assign hit_f      = hit_f0 || hit_f1;
  assign way_f      = !hit_f0;
  assign ent_f      = way_f ? f1 : f0;
  assign stored_tgt = {ent_f.target, 2'b00};

  assign hit_m0 = m0.valid && (m0.tag == tag_m);
  assign hit_m1 = m1.valid && (m1.tag == tag_m);
  assign hit_m  = hit_m0 || hit_m1;
  assign way_m  = hit_m   ? !hit_m0 :
                  !m0.valid ? 1'b0 :
                  !m1.valid ? 1'b1 : lru[idx_m];

  assign new_ent = '{valid: 1'b1, tag: tag_m, target: targetM[31:2], kind: kind_m};

  assign unused_common = ^{idx_f_full[31:SET_DEPTH], idx_m_full[31:SET_DEPTH],
                           tag_f_full[31:TAG_W_MAX], tag_m_full[31:TAG_W_MAX], targetM[1:0]};

`ifdef BTB_RAS_EN
  logic [31:0] ras_top;
  logic        ras_empty;
  logic        unused_ras;

  btb_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (branchM & callM),
    .pop       (branchM & retM),
    .push_addr (pcM + 32'd8),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign kind_m     = callM ? KIND_CALL : (retM ? KIND_RET : KIND_BR);
  assign tgt_f      = (ent_f.kind == KIND_RET && !ras_empty) ? {ras_top[31:2], 2'b00} : stored_tgt;
  assign unused_ras = ^ras_top[1:0];
`else
  logic [31:0] unused_cfg;

  assign kind_m     = KIND_BR;
  assign tgt_f      = stored_tgt;
  assign unused_cfg = {30'(RAS_DEPTH), callM, retM};
`endif

  assign branchF = hit_f;
  assign targetF = hit_f ? tgt_f : 32'd0;

  // The M-stage LRU write is ordered last so it wins over an F hit to the same set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSETS; s++) begin
        tbl[0][s] <= '0;
        tbl[1][s] <= '0;
        lru[s]    <= 1'b0;
      end
    end else begin
      if (hit_f && !stallD) lru[idx_f] <= ~way_f;
      if (branchM) begin
        if (hit_m) begin
          lru[idx_m] <= ~way_m;
          if (actual_takeM) begin
            tbl[way_m][idx_m].target <= targetM[31:2];
            tbl[way_m][idx_m].kind   <= kind_m;
          end
        end else if (actual_takeM) begin
          tbl[way_m][idx_m] <= new_ent;
          lru[idx_m]        <= ~way_m;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      btb_hitD    <= 1'b0;
      btb_targetD <= 32'd0;
    end else if (!stallD) begin
      btb_hitD    <= branchF;
      btb_targetD <= targetF;
    end
  end

endmodule

`default_nettype wire
